inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives `pc_o` into the memory's byte address input; the memory returns `inst_i` combinationally in the same cycle.
- Buffers fetched instructions in a 2-entry queue with a valid/ready handshake toward decode.
- Handles branch/jump redirects and traps (flush), and flags misaligned targets and out-of-range fetches.

Parameters:
- REG_SIZE, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_SIZE_IN_KB, 1, instruction memory size; fetches at or beyond MEM_SIZE_IN_KB*1024 bytes are out of range.
- NOP_INST, 32'h0000_0013, instruction substituted for out-of-range fetches (addi x0,x0,0).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- pc_o, output, REG_SIZE, current fetch address; drives the instruction memory address input.
- inst_i, input, REG_SIZE, instruction word read at pc_o, combinational same cycle.
- fetch_en_i, input, 1, permits fetching; 0 freezes the PC (queue still drains).
- redirect_i, input, 1, branch/jump taken; flush and load redirect_pc_i.
- redirect_pc_i, input, REG_SIZE, redirect target.
- trap_i, input, 1, trap/exception entry; flush and load trap_pc_i; priority over redirect_i.
- trap_pc_i, input, REG_SIZE, trap vector.
- valid_o, output, 1, queue head holds an instruction.
- ready_i, input, 1, decode accepts the head this cycle.
- inst_o, output, REG_SIZE, head instruction.
- inst_pc_o, output, REG_SIZE, PC of the head instruction.
- fault_o, output, 1, head instruction came from an out-of-range address.
- misalign_o, output, 1, registered one-cycle pulse: the accepted redirect/trap target had addr[1:0] != 0.

Behaviour:
- Reset (async, rst_n=0):
  - pc_q = RESET_PC; queue count = 0.
  - valid_o = 0, misalign_o = 0.
  - inst_o, inst_pc_o and fault_o read 0.
  - Reset asserted mid-operation discards all queued entries immediately.
- pc_o = pc_q, combinationally.
- Pop: occurs when valid_o && ready_i. valid_o = (count != 0).
- Push condition: fetch_en_i && !trap_i && !redirect_i && (count<2 || pop).
  - Writes {inst_i, pc_q, fault} at the tail.
  - pc_q <= pc_q + 4, modulo 2^REG_SIZE (0xFFFF_FFFC wraps to 0).
- Out of range (pc_q >= MEM_SIZE_IN_KB*1024): the stored instruction is NOP_INST and the entry's fault bit is 1; pc still increments.
- Queue: 2-entry FIFO, count 0..2.
  - Push and pop in the same cycle: count unchanged, allowed even when full.
  - Empty with push: entry becomes visible the next cycle (no same-cycle bypass).
  - Full without pop: no push, pc_q holds.
- Flush (trap_i or redirect_i high at a clock edge):
  - count <= 0; no push that cycle.
  - A pop in the same cycle still counts as consumed by decode.
  - pc_q <= {target[REG_SIZE-1:2], 2'b00}, where target = trap_pc_i if trap_i else redirect_pc_i.
  - misalign_o <= (target[1:0] != 0); otherwise misalign_o <= 0.
- Flush latency: flush at edge N; pc_o = target during cycle N+1; valid_o = 1 in cycle N+2 at the earliest.
- Steady state: one instruction per cycle when ready_i=1 and fetch_en_i=1.
- fetch_en_i=0: pc_q holds and no push occurs; pops continue; a flush is still honoured.
- Output stability: head outputs are registered and change only on a pop, push-into-empty, flush or reset.

Test Plan:
- Reset release, fetch_en_i=1, ready_i=1: pc_o = 0x0, 0x4, 0x8; valid_o rises 1 cycle after reset release; inst_pc_o follows 0x0, 0x4, 0x8 and inst_o matches memory words 0..2.
- Backpressure: ready_i=0 for 5 cycles → count saturates at 2, pc_o stalls at 0x8, head stays pc 0x0. Then ready_i=1 → pcs 0x0, 0x4, 0x8 delivered in order with no loss or duplication.
- redirect_i with redirect_pc_i=0x40 while queue is full → valid_o=0 next cycle, pc_o=0x40, next delivered inst_pc_o=0x40; stale entries 0x0/0x4 never appear.
- trap_i (trap_pc_i=0x100) and redirect_i (0x40) in the same cycle → pc_o=0x100. redirect_pc_i=0x42 → pc_o=0x40 and misalign_o high for exactly one cycle.
- Sequential fetch up to pc 0x3FC then 0x400 with MEM_SIZE_IN_KB=1 → entry 0x3FC has fault_o=0; entry 0x400 has inst_o=0x0000_0013 and fault_o=1.
- rst_n pulled low mid-stream with 2 entries queued → valid_o=0 immediately (asynchronous); after release pc_o=RESET_PC and fetching restarts.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-to-decode handshake: registered queue head plus the misalignment pulse.
// The fetch stage is the master; decode drives ready_i back.
interface inst_fetch_if #(
    parameter int REG_SIZE = 32
);
    logic                valid_o;
    logic                ready_i;
    logic [REG_SIZE-1:0] inst_o;
    logic [REG_SIZE-1:0] inst_pc_o;
    logic                fault_o;
    logic                misalign_o;

    modport master (
        output valid_o,
        output inst_o,
        output inst_pc_o,
        output fault_o,
        output misalign_o,
        input  ready_i
    );

    modport slave (
        input  valid_o,
        input  inst_o,
        input  inst_pc_o,
        input  fault_o,
        input  misalign_o,
        output ready_i
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory and
// buffers fetched words in a 2-entry queue toward decode, with redirect/trap flushing.
module inst_fetch #(
    parameter int                  REG_SIZE       = 32,
    parameter logic [REG_SIZE-1:0] RESET_PC       = '0,
    parameter int                  MEM_SIZE_IN_KB = 1,
    parameter logic [REG_SIZE-1:0] NOP_INST       = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [REG_SIZE-1:0] pc_o,
    input  logic [REG_SIZE-1:0] inst_i,
    input  logic                fetch_en_i,
    input  logic                redirect_i,
    input  logic [REG_SIZE-1:0] redirect_pc_i,
    input  logic                trap_i,
    input  logic [REG_SIZE-1:0] trap_pc_i,
    inst_fetch_if.master        dec
);

    localparam int DEPTH = 2;
    localparam int AW1   = REG_SIZE + 1;
    // One extra bit so a memory filling the whole address space still compares correctly.
    localparam logic [AW1-1:0] MEM_BYTES = AW1'(MEM_SIZE_IN_KB * 1024);

    logic [REG_SIZE-1:0] r_pc;
    logic [1:0]          r_count;
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic                r_misalign;

    logic [REG_SIZE-1:0] r_ent_inst  [DEPTH];
    logic [REG_SIZE-1:0] r_ent_pc    [DEPTH];
    logic                r_ent_fault [DEPTH];

    logic                w_pop;
    logic                w_push;
    logic                w_flush;
    logic                w_oor;
    logic [REG_SIZE-1:0] w_target;
    logic [REG_SIZE-1:0] w_fetch_inst;

    assign w_flush      = trap_i | redirect_i;
    assign w_target     = trap_i ? trap_pc_i : redirect_pc_i;
    assign w_pop        = (r_count != 2'd0) && dec.ready_i;
    assign w_push       = fetch_en_i && !w_flush && ((r_count != 2'd2) || w_pop);
    assign w_oor        = ({1'b0, r_pc} >= MEM_BYTES);
    assign w_fetch_inst = w_oor ? NOP_INST : inst_i;

    assign pc_o = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_flush && (w_target[1:0] != 2'b00);
            if (w_flush) begin
                // Any pop this cycle is already consumed by decode; the rest is discarded.
                r_pc     <= {w_target[REG_SIZE-1:2], 2'b00};
                r_count  <= 2'd0;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
            end else begin
                if (w_push) begin
                    r_pc     <= r_pc + REG_SIZE'(4);
                    r_wr_ptr <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // When full with a simultaneous pop, the tail slot is the head being consumed.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ent_inst[gi]  <= '0;
                    r_ent_pc[gi]    <= '0;
                    r_ent_fault[gi] <= 1'b0;
                end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                    r_ent_inst[gi]  <= w_fetch_inst;
                    r_ent_pc[gi]    <= r_pc;
                    r_ent_fault[gi] <= w_oor;
                end
            end
        end
    endgenerate

    assign dec.valid_o    = (r_count != 2'd0);
    assign dec.inst_o     = r_ent_inst[r_rd_ptr];
    assign dec.inst_pc_o  = r_ent_pc[r_rd_ptr];
    assign dec.fault_o    = r_ent_fault[r_rd_ptr];
    assign dec.misalign_o = r_misalign;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random traffic, every cycle compared
// against a queue-based model of the fetch/flush rules.
module tb_inst_fetch;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [31:0] MEM_BYTES = 32'd1024;
    localparam logic [31:0] RST_PC    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] inst_i;
    logic        fetch_en_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        trap_i;
    logic [31:0] trap_pc_i;

    inst_fetch_if #(.REG_SIZE(32)) dec_if ();

    inst_fetch #(
        .REG_SIZE       (32),
        .RESET_PC       (RST_PC),
        .MEM_SIZE_IN_KB (1),
        .NOP_INST       (NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_o          (pc_o),
        .inst_i        (inst_i),
        .fetch_en_i    (fetch_en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .trap_i        (trap_i),
        .trap_pc_i     (trap_pc_i),
        .dec           (dec_if)
    );

    always #5 clk = ~clk;

    // Instruction memory; out-of-range reads return junk the DUT must replace.
    logic [31:0] mem [256];
    always_comb inst_i = (pc_o < MEM_BYTES) ? mem[pc_o[9:2]] : (32'hBAD0_0000 ^ pc_o);

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_mis;
    bit          verbose;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("pc_o", pc_o, m_pc);
        chk("valid_o", 32'(dec_if.valid_o), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("inst_o", dec_if.inst_o, mq[0].inst);
            chk("inst_pc_o", dec_if.inst_pc_o, mq[0].pc);
            chk("fault_o", 32'(dec_if.fault_o), 32'(mq[0].fault));
        end
        chk("misalign_o", 32'(dec_if.misalign_o), 32'(m_mis));
    endtask

    // Drive one cycle's inputs and advance the model across the coming rising edge.
    task automatic drive_and_model(input bit fe, input bit rdy, input bit rd, input logic [31:0] rdpc,
                                   input bit tr, input logic [31:0] trpc);
        bit          pop;
        bit          push;
        logic [31:0] tgt;
        ent_t        e;
        fetch_en_i     = fe;
        dec_if.ready_i = rdy;
        redirect_i     = rd;
        redirect_pc_i  = rdpc;
        trap_i         = tr;
        trap_pc_i      = trpc;
        pop  = (mq.size() != 0) && rdy;
        push = fe && !(tr || rd) && ((mq.size() < 2) || pop);
        if (pop) begin
            if (verbose)
                $display("xfer pc=%h inst=%h fault=%0d", mq[0].pc, mq[0].inst, mq[0].fault);
            void'(mq.pop_front());
        end
        if (tr || rd) begin
            tgt = tr ? trpc : rdpc;
            mq.delete();
            m_pc  = tgt & ~32'h3;
            m_mis = (tgt[1:0] != 2'b00);
            if (verbose) $display("flush target=%h trap=%0d", tgt, tr);
        end else begin
            m_mis = 1'b0;
            if (push) begin
                e.pc    = m_pc;
                e.fault = (m_pc >= MEM_BYTES);
                e.inst  = e.fault ? NOP : mem[m_pc[9:2]];
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic cycle(input bit fe, input bit rdy, input bit rd, input logic [31:0] rdpc,
                         input bit tr, input logic [31:0] trpc);
        @(negedge clk);
        check_outputs();
        drive_and_model(fe, rdy, rd, rdpc, tr, trpc);
    endtask

    task automatic run(input int n, input bit fe, input bit rdy);
        for (int i = 0; i < n; i++) cycle(fe, rdy, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic redirect(input logic [31:0] tgt, input bit rdy);
        cycle(1'b1, rdy, 1'b1, tgt, 1'b0, 32'h0);
    endtask

    // Reset asserted mid-cycle so the checks show it takes effect without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid_o", 32'(dec_if.valid_o), 32'h0);
        chk("rst_pc_o", pc_o, RST_PC);
        chk("rst_inst_o", dec_if.inst_o, 32'h0);
        chk("rst_inst_pc_o", dec_if.inst_pc_o, 32'h0);
        chk("rst_fault_o", 32'(dec_if.fault_o), 32'h0);
        chk("rst_misalign_o", 32'(dec_if.misalign_o), 32'h0);
        mq.delete();
        m_pc  = RST_PC;
        m_mis = 1'b0;
        $display("reset asserted");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        drive_and_model(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        bit          fe;
        bit          rdy;
        bit          rd;
        bit          tr;
        logic [31:0] t0;
        logic [31:0] t1;
        fetch_en_i     = 1'b0;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        trap_i         = 1'b0;
        trap_pc_i      = 32'h0;
        dec_if.ready_i = 1'b0;
        verbose        = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        m_pc  = RST_PC;
        m_mis = 1'b0;

        // Streaming from reset
        do_reset();
        run(6, 1'b1, 1'b1);

        // Backpressure then drain
        do_reset();
        run(5, 1'b1, 1'b0);
        run(5, 1'b1, 1'b1);

        // Redirect while full: stale entries must vanish
        run(4, 1'b1, 1'b0);
        redirect(32'h0000_0040, 1'b0);
        run(4, 1'b1, 1'b1);

        // Trap wins over redirect; then a misaligned redirect
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0100);
        run(3, 1'b1, 1'b1);
        redirect(32'h0000_0042, 1'b1);
        run(3, 1'b1, 1'b1);

        // Crossing the end of instruction memory
        redirect(32'h0000_03F4, 1'b1);
        run(6, 1'b1, 1'b1);

        // PC wraps past the top of the address space
        redirect(32'hFFFF_FFF8, 1'b1);
        run(4, 1'b1, 1'b1);

        // Fetch disabled: queue drains, pc frozen, flush still honoured
        run(2, 1'b1, 1'b0);
        run(3, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0083, 1'b0, 32'h0);
        run(2, 1'b0, 1'b1);
        run(3, 1'b1, 1'b1);

        // Asynchronous reset with two entries queued
        run(4, 1'b1, 1'b0);
        do_reset();
        run(4, 1'b1, 1'b1);

        // Random traffic
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            fe  = ($urandom_range(0, 99) < 80);
            rdy = ($urandom_range(0, 99) < 70);
            rd  = ($urandom_range(0, 99) < 5);
            tr  = ($urandom_range(0, 99) < 3);
            t0  = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 32'h47F))
                                              : 32'($urandom_range(32'h3E0, 32'h41F));
            t1  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h47F));
            cycle(fe, rdy, rd, t0, tr, t1);
        end

        @(negedge clk);
        check_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
